// File: rtl/iodelay_ctrl_manager.sv
// Reset/ready sequencer for a group of IDELAYCTRL primitives sharing one refclk.
// Pulses RST for a fixed hold time, waits (with timeout) for every enabled RDY,
// retries a bounded number of times, and re-sequences on RDY loss or recal_i.
module iodelay_ctrl_manager #(
  parameter int num_ctrl_p    = 1,
  parameter int sync_depth_p  = 4,
  parameter int hold_cycles_p = 15,
  parameter int rdy_sync_p    = 2,
  parameter int rdy_timeout_p = 1024,
  parameter int max_retries_p = 3
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 recal_i,
  input  logic [num_ctrl_p-1:0]                ctrl_en_i,
  input  logic [num_ctrl_p-1:0]                rdy_i,
  output logic [num_ctrl_p-1:0]                idelayctrl_rst_o,
  output logic                                 ready_o,
  output logic                                 fail_o,
  output logic [1:0]                           state_o,
  output logic [$clog2(max_retries_p+2)-1:0]   retry_cnt_o
);

  localparam int hold_w_lp  = $clog2(hold_cycles_p + 1);
  localparam int timer_w_lp = $clog2(rdy_timeout_p);
  localparam int retry_w_lp = $clog2(max_retries_p + 2);

  localparam logic [hold_w_lp-1:0]  hold_init_lp = hold_w_lp'(hold_cycles_p);
  localparam logic [timer_w_lp-1:0] timer_max_lp = timer_w_lp'(rdy_timeout_p - 1);
  localparam logic [retry_w_lp-1:0] retry_max_lp = retry_w_lp'(max_retries_p);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  // Internal reset: asserted asynchronously, released after sync_depth_p clean edges.
  logic [sync_depth_p-1:0] rst_sync_q;
  logic                    int_rst_n;

  // Reset synchroniser shift chain (ones while reset_n_i is low, zeros shift in after).
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_q <= '1;
    else            rst_sync_q <= {rst_sync_q[sync_depth_p-2:0], 1'b0};
  end

  assign int_rst_n = ~rst_sync_q[sync_depth_p-1];

  // RDY comes from the IDELAYCTRL without a relationship to clk_i; resample it.
  logic [rdy_sync_p-1:0][num_ctrl_p-1:0] rdy_pipe_q;
  logic [num_ctrl_p-1:0]                 rdy_s;
  logic                                  all_rdy;

  // RDY synchroniser pipeline, stage 0 samples the raw input.
  always_ff @(posedge clk_i or negedge int_rst_n) begin
    if (!int_rst_n) begin
      rdy_pipe_q <= '0;
    end else begin
      rdy_pipe_q[0] <= rdy_i;
      for (int i = 1; i < rdy_sync_p; i++) rdy_pipe_q[i] <= rdy_pipe_q[i-1];
    end
  end

  assign rdy_s   = rdy_pipe_q[rdy_sync_p-1];
  // Disabled channels count as ready so they never block the group.
  assign all_rdy = &(rdy_s | ~ctrl_en_i);

  state_t                  state_q, state_d;
  logic [hold_w_lp-1:0]    hold_cnt_q, hold_cnt_d;
  logic [timer_w_lp-1:0]   timer_q, timer_d;
  logic [retry_w_lp-1:0]   retry_q, retry_d;
  logic [num_ctrl_p-1:0]   rst_q, rst_d;
  logic                    ready_q, ready_d;
  logic                    fail_q, fail_d;

  // Next-state logic; recal_i overrides every other transition.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    timer_d    = '0;
    retry_d    = retry_q;
    if (recal_i) begin
      state_d    = ST_HOLD;
      hold_cnt_d = hold_init_lp;
      retry_d    = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q <= hold_w_lp'(1)) begin
            state_d    = ST_WAIT;
            hold_cnt_d = hold_init_lp;
          end else begin
            hold_cnt_d = hold_cnt_q - hold_w_lp'(1);
          end
        end
        ST_WAIT: begin
          if (all_rdy) begin
            state_d = ST_READY;
            retry_d = '0;
          end else if (timer_q == timer_max_lp) begin
            if (retry_q == retry_max_lp) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_HOLD;
              retry_d = retry_q + retry_w_lp'(1);
            end
          end else begin
            timer_d = timer_q + timer_w_lp'(1);
          end
        end
        ST_READY: begin
          if (!all_rdy) state_d = ST_HOLD;
        end
        default: begin
          state_d = ST_FAIL;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with state_q.
  always_comb begin
    rst_d   = ~ctrl_en_i;
    ready_d = 1'b0;
    fail_d  = 1'b0;
    case (state_d)
      ST_HOLD:  rst_d   = '1;
      ST_READY: ready_d = 1'b1;
      ST_FAIL: begin
        rst_d  = '1;
        fail_d = 1'b1;
      end
      default:  rst_d   = ~ctrl_en_i;
    endcase
  end

  // State, counters and registered outputs; internal reset forces HOLD immediately.
  always_ff @(posedge clk_i or negedge int_rst_n) begin
    if (!int_rst_n) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= hold_init_lp;
      timer_q    <= '0;
      retry_q    <= '0;
      rst_q      <= '1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      rst_q      <= rst_d;
      ready_q    <= ready_d;
      fail_q     <= fail_d;
    end
  end

  assign idelayctrl_rst_o = rst_q;
  assign ready_o          = ready_q;
  assign fail_o           = fail_q;
  assign state_o          = state_q;
  assign retry_cnt_o      = retry_q;

endmodule
